// File: rtl/as_wb_bridge_p.sv
// Byte-serial command to WishBone master bridge: single read/write, burst read, status replies.
// Optional macro AS_WB_TIMEOUT_EN aborts a WishBone cycle after WB_TIMEOUT unanswered cycles.
module as_wb_bridge_p #(
  parameter int ADDR_BYTES = 2,
  parameter int DATA_BYTES = 2,
  parameter int WB_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              as_data_i,
  input  logic                    as_dstrb_i,
  output logic                    as_busy_o,
  output logic [7:0]              as_data_o,
  output logic                    as_dstrb_o,
  input  logic                    as_busy_i,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [8*ADDR_BYTES-1:0] wb_adr_o,
  output logic [8*DATA_BYTES-1:0] wb_dat_o,
  input  logic [8*DATA_BYTES-1:0] wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int AW   = 8 * ADDR_BYTES;
  localparam int DW   = 8 * DATA_BYTES;
  localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int BW   = $clog2(MAXB) + 1;
  localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_BYTES - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BYTES - 1);

  localparam logic [1:0] CMD_RD = 2'd1;
  localparam logic [1:0] CMD_WR = 2'd2;
  localparam logic [1:0] CMD_BR = 2'd3;

  localparam logic [7:0] ST_ACK    = 8'h01;
  localparam logic [7:0] ST_ERR    = 8'h02;
  localparam logic [7:0] ST_BADCMD = 8'h03;

  typedef enum logic [2:0] {
    S_CMD, S_ADDR, S_DATA, S_CNT, S_WB, S_STAT, S_RDATA
  } state_t;

  state_t          r_state;
  logic [1:0]      r_cmd;
  logic [BW-1:0]   r_bcnt;
  logic [7:0]      r_beats;
  logic [7:0]      r_status;
  logic [DW-1:0]   r_rdata;
  logic [AW-1:0]   r_adr;
  logic [DW-1:0]   r_wdat;
  logic            r_cyc;
  logic            r_stb;
  logic            r_we;
  logic [7:0]      r_dout;
  logic            r_dstrb;
  logic            w_accept;
  logic            w_tmo_hit;

  assign as_busy_o  = !(r_state == S_CMD || r_state == S_ADDR ||
                        r_state == S_DATA || r_state == S_CNT);
  assign w_accept   = as_dstrb_i && !as_busy_o;
  assign as_data_o  = r_dout;
  assign as_dstrb_o = r_dstrb;
  assign wb_cyc_o   = r_cyc;
  assign wb_stb_o   = r_stb;
  assign wb_we_o    = r_we;
  assign wb_adr_o   = r_adr;
  assign wb_dat_o   = r_wdat;

`ifdef AS_WB_TIMEOUT_EN
  localparam int TW = $clog2(WB_TIMEOUT + 1);
  logic [TW-1:0] r_tmo;

  // Fires on the edge that would bring the count to WB_TIMEOUT
  assign w_tmo_hit = r_cyc && (r_tmo == TW'(WB_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset || r_state != S_WB || !r_cyc) r_tmo <= '0;
    else                                     r_tmo <= r_tmo + TW'(1);
  end
`else
  // No timeout: a stalled slave holds the bridge until ack/err
  assign w_tmo_hit = (WB_TIMEOUT < 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_CMD;
      r_cmd    <= 2'd0;
      r_bcnt   <= '0;
      r_beats  <= 8'd0;
      r_status <= 8'd0;
      r_rdata  <= '0;
      r_adr    <= '0;
      r_wdat   <= '0;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_we     <= 1'b0;
      r_dout   <= 8'd0;
      r_dstrb  <= 1'b0;
    end else begin
      r_dstrb <= 1'b0;
      case (r_state)
        S_CMD: if (w_accept) begin
          r_bcnt  <= '0;
          r_beats <= 8'd0;
          if (as_data_i == 8'h01 || as_data_i == 8'h02 || as_data_i == 8'h03) begin
            r_cmd   <= as_data_i[1:0];
            r_state <= S_ADDR;
          end else begin
            r_cmd    <= 2'd0;
            r_status <= ST_BADCMD;
            r_state  <= S_STAT;
          end
        end
        S_ADDR: if (w_accept) begin
          r_adr[8*r_bcnt +: 8] <= as_data_i;
          if (r_bcnt == ADDR_LAST) begin
            r_bcnt <= '0;
            case (r_cmd)
              CMD_WR:  r_state <= S_DATA;
              CMD_BR:  r_state <= S_CNT;
              default: r_state <= S_WB;
            endcase
          end else begin
            r_bcnt <= r_bcnt + BW'(1);
          end
        end
        S_DATA: if (w_accept) begin
          r_wdat[8*r_bcnt +: 8] <= as_data_i;
          if (r_bcnt == DATA_LAST) begin
            r_bcnt  <= '0;
            r_state <= S_WB;
          end else begin
            r_bcnt <= r_bcnt + BW'(1);
          end
        end
        S_CNT: if (w_accept) begin
          r_beats <= as_data_i;
          r_state <= S_WB;
        end
        // First cycle in WB raises the strobe; afterwards wait for ack/err/timeout
        S_WB: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_we  <= (r_cmd == CMD_WR);
          end else if (wb_err_i || w_tmo_hit) begin
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_we     <= 1'b0;
            r_status <= ST_ERR;
            r_state  <= S_STAT;
          end else if (wb_ack_i) begin
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_we     <= 1'b0;
            r_rdata  <= wb_dat_i;
            r_status <= ST_ACK;
            r_state  <= S_STAT;
          end
        end
        S_STAT: if (!as_busy_i) begin
          r_dout  <= r_status;
          r_dstrb <= 1'b1;
          r_bcnt  <= '0;
          if (r_status == ST_ACK && r_cmd != CMD_WR) r_state <= S_RDATA;
          else                                       r_state <= S_CMD;
        end
        S_RDATA: if (!as_busy_i) begin
          r_dout  <= r_rdata[8*r_bcnt +: 8];
          r_dstrb <= 1'b1;
          if (r_bcnt == DATA_LAST) begin
            r_bcnt <= '0;
            if (r_beats != 8'd0) begin
              r_beats <= r_beats - 8'd1;
              r_adr   <= r_adr + AW'(1);
              r_state <= S_WB;
            end else begin
              r_state <= S_CMD;
            end
          end else begin
            r_bcnt <= r_bcnt + BW'(1);
          end
        end
        default: r_state <= S_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_as_wb_bridge_p.sv
// Directed bench for as_wb_bridge_p with a memory-backed WishBone slave model.
// Timeout scenario is included when AS_WB_TIMEOUT_EN is defined.
module tb_as_wb_bridge_p;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  as_data_i = 8'h00;
  logic        as_dstrb_i = 1'b0;
  logic        as_busy_o;
  logic [7:0]  as_data_o;
  logic        as_dstrb_o;
  logic        as_busy_i = 1'b0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [15:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_ack_i, wb_err_i;

  int total = 0;
  int bad = 0;

  logic [15:0] mem [0:65535];
  logic        do_preload = 1'b0;
  logic        stall = 1'b0;
  logic        err_en = 1'b0;
  logic [15:0] err_adr = 16'h0000;
  logic [7:0]  rx [$];
  logic [7:0]  exp_q [$];
  logic [15:0] rd_adr [$];
  logic        busy_q = 1'b0;
  int          busy_viol = 0;

  as_wb_bridge_p #(.ADDR_BYTES(2), .DATA_BYTES(2), .WB_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .as_data_i(as_data_i), .as_dstrb_i(as_dstrb_i), .as_busy_o(as_busy_o),
    .as_data_o(as_data_o), .as_dstrb_o(as_dstrb_o), .as_busy_i(as_busy_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  // Zero-wait slave: combinational ack/err, combinational read data
  assign wb_err_i = wb_cyc_o && wb_stb_o && err_en && (wb_adr_o == err_adr);
  assign wb_ack_i = wb_cyc_o && wb_stb_o && !stall && !wb_err_i;
  assign wb_dat_i = mem[wb_adr_o];

  always @(posedge clk) begin
    if (do_preload) begin
      for (int a = 0; a < 65536; a++) mem[a] <= ~16'(a);
    end else if (wb_ack_i && wb_we_o) begin
      mem[wb_adr_o] <= wb_dat_o;
    end
    if (wb_ack_i && !wb_we_o) rd_adr.push_back(wb_adr_o);
    busy_q <= as_busy_i;
  end

  always @(negedge clk) begin
    if (as_dstrb_o) begin
      rx.push_back(as_data_o);
      if (busy_q) busy_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (as_busy_o && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("send_wait", 32'(as_busy_o), 32'd0);
    as_data_i  = b;
    as_dstrb_i = 1'b1;
    tick();
    as_dstrb_i = 1'b0;
  endtask

  task automatic check_rx(input string tag);
    int n = 0;
    while (rx.size() < exp_q.size() && n < 300) begin
      tick();
      n++;
    end
    repeat (6) tick();
    chk($sformatf("%s_count", tag), 32'(rx.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx.size()) chk($sformatf("%s_byte%0d", tag, i), 32'(rx[i]), 32'(exp_q[i]));
    end
    rx.delete();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_dstrb", 32'(as_dstrb_o), 32'd0);
    chk("rst_busy", 32'(as_busy_o), 32'd0);
    chk("rst_adr", 32'(wb_adr_o), 32'd0);
    chk("rst_dat", 32'(wb_dat_o), 32'd0);
    reset = 1'b1;
    tick();

    // Single write: 02 05 00 CD AB
    send_byte(8'h02); send_byte(8'h05); send_byte(8'h00); send_byte(8'hCD); send_byte(8'hAB);
    chk("wr_cyc_entry", 32'(wb_cyc_o), 32'd0);
    tick();
    chk("wr_cyc", 32'(wb_cyc_o), 32'd1);
    chk("wr_stb", 32'(wb_stb_o), 32'd1);
    chk("wr_we", 32'(wb_we_o), 32'd1);
    chk("wr_adr", 32'(wb_adr_o), 32'h0005);
    chk("wr_dat", 32'(wb_dat_o), 32'hABCD);
    tick();
    chk("wr_cyc_drop", 32'(wb_cyc_o), 32'd0);
    exp_q = '{8'h01};
    check_rx("wr_resp");

    // Read back: 01 05 00
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h00);
    exp_q = '{8'h01, 8'hCD, 8'hAB};
    check_rx("rd_resp");

    // Burst with address wrap: 03 FE FF 02
    do_preload = 1'b1;
    tick();
    do_preload = 1'b0;
    rd_adr.delete();
    send_byte(8'h03); send_byte(8'hFE); send_byte(8'hFF); send_byte(8'h02);
    exp_q = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF};
    check_rx("burst");
    chk("burst_nrd", 32'(rd_adr.size()), 32'd3);
    if (rd_adr.size() == 3) begin
      chk("burst_adr0", 32'(rd_adr[0]), 32'hFFFE);
      chk("burst_adr1", 32'(rd_adr[1]), 32'hFFFF);
      chk("burst_adr2", 32'(rd_adr[2]), 32'h0000);
    end

    // Burst of 4 with err on the second beat
    err_en  = 1'b1;
    err_adr = 16'h0011;
    send_byte(8'h03); send_byte(8'h10); send_byte(8'h00); send_byte(8'h03);
    exp_q = '{8'h01, 8'hEF, 8'hFF, 8'h02};
    check_rx("berr");
    chk("berr_cyc", 32'(wb_cyc_o), 32'd0);
    err_en = 1'b0;
    send_byte(8'h01); send_byte(8'h20); send_byte(8'h00);
    exp_q = '{8'h01, 8'hDF, 8'hFF};
    check_rx("after_err");

    // Downstream busy held during a read response
    busy_viol = 0;
    send_byte(8'h01); send_byte(8'h30); send_byte(8'h00);
    as_busy_i = 1'b1;
    repeat (10) tick();
    chk("busy_hold_rx", 32'(rx.size()), 32'd0);
    as_busy_i = 1'b0;
    exp_q = '{8'h01, 8'hCF, 8'hFF};
    check_rx("busy_resp");
    chk("busy_viol", 32'(busy_viol), 32'd0);

    // Bad command
    send_byte(8'h7F);
    exp_q = '{8'h03};
    check_rx("badcmd");

    // Reset while a write cycle is stalled
    stall = 1'b1;
    send_byte(8'h02); send_byte(8'h40); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    tick();
    chk("mid_cyc", 32'(wb_cyc_o), 32'd1);
    reset = 1'b0;
    tick();
    chk("mid_rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("mid_rst_stb", 32'(wb_stb_o), 32'd0);
    chk("mid_rst_busy", 32'(as_busy_o), 32'd0);
    reset = 1'b1;
    stall = 1'b0;
    tick();
    chk("mid_no_write", 32'(mem[16'h0040]), 32'hFFBF);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    exp_q = '{8'h01, 8'hFF, 8'hFF};
    check_rx("post_rst");

`ifdef AS_WB_TIMEOUT_EN
    begin
      int k = 0;
      int seen = 0;
      stall = 1'b1;
      send_byte(8'h01); send_byte(8'h50); send_byte(8'h00);
      tick();
      chk("tmo_stb", 32'(wb_stb_o), 32'd1);
      while (!as_dstrb_o && k < 40) begin
        tick();
        k++;
      end
      seen = k;
      chk("tmo_latency", 32'(seen), 32'd9);
      chk("tmo_status", 32'(as_data_o), 32'h02);
      stall = 1'b0;
      rx.delete();
      repeat (4) tick();
      chk("tmo_cyc", 32'(wb_cyc_o), 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
